// File: rtl/f32_result_collector.sv
// Result collector for the fixed-latency f32 operators.
// Valid-only operator results go into a first-word fall-through FIFO, which is
// drained on a ready/valid stream. Credits (issue_ok) gate upstream launches so
// that every launched result is guaranteed a free slot when it arrives.
module f32_result_collector #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             s_axis_result_tvalid,
    input  logic [WIDTH-1:0] s_axis_result_tdata,
    input  logic             issue_valid,
    output logic             issue_ok,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    inflight,
    output logic             overflow,
    output logic             unexpected
);

    localparam int unsigned   AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] Full  = CW'(DEPTH);
    // Credit limit is compared at one extra bit so count + inflight cannot wrap.
    localparam logic [CW:0]   Limit = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          overflow_q, overflow_d;
    logic          unexpected_q, unexpected_d;

    logic          push, pop, fire, full, wr_en;
    logic [CW:0]   committed;

    // Event decode, credit check and next-state computation.
    always_comb begin
        push      = s_axis_result_tvalid;
        pop       = (count_q != '0) & m_axis_tready;
        committed = {1'b0, count_q} + {1'b0, inflight_q};
        issue_ok  = committed < Limit;
        fire      = issue_valid & issue_ok;
        full      = count_q == Full;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en     = push & (~full | pop);

        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        overflow_d   = overflow_q | (push & full & ~pop);
        unexpected_d = unexpected_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (fire && !push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (push && !fire) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CW'(1);
            end else begin
                // Result with no matching launch: saturate and flag it.
                unexpected_d = 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge aclk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            overflow_q   <= 1'b0;
            unexpected_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            overflow_q   <= overflow_d;
            unexpected_q <= unexpected_d;
        end
    end

    // Storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge aclk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q] <= s_axis_result_tdata;
        end
    end

    assign m_axis_tvalid = count_q != '0;
    assign m_axis_tdata  = mem[rd_ptr_q];
    assign count         = count_q;
    assign inflight      = inflight_q;
    assign overflow      = overflow_q;
    assign unexpected    = unexpected_q;

endmodule
